arb_rr_4_1: RTL and testbench

Four-channel round-robin arbiter with a registered output stage. It sits directly upstream of the 4-bit 4:1 data mux. It computes the channel select that drives `mux_4_1` and captures the selected word into a single-entry output register with valid/ready handshake. An optional burst allowance lets one channel hold the grant for several consecutive transfers.

---
 rtl/arb_pkg.sv | 23 ++
 rtl/mux_4_1.sv | 18 +
 rtl/arb_rr_4_1.sv | 82 ++++++++
 tb/tb_arb_rr_4_1.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types, sizes and the rotate-priority picker for the 4:1 round-robin arbiter.
package arb_pkg;
   localparam int N_CH   = 4;
   localparam int DATA_W = 4;

   typedef logic [1:0] ch_t;
   typedef logic [3:0] cnt_t;

   // First requester in order last+1, last+2, last+3, last (mod 4); returns last if none.
   function automatic ch_t rr_pick(input logic [N_CH-1:0] req, input ch_t last);
      ch_t  idx;
      logic found;
      rr_pick = last;
      found   = 1'b0;
      for (int k = 1; k <= N_CH; k++) begin
         idx = last + ch_t'(k);
         if (!found && req[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction
endpackage

// File: rtl/mux_4_1.sv
// 4:1 data word mux driven by the arbiter grant index.
module mux_4_1 import arb_pkg::*; (
   input  logic [DATA_W-1:0] d0,
   input  logic [DATA_W-1:0] d1,
   input  logic [DATA_W-1:0] d2,
   input  logic [DATA_W-1:0] d3,
   input  ch_t               sel,
   output logic [DATA_W-1:0] y
);
   always_comb begin
      case (sel)
         2'd0:    y = d0;
         2'd1:    y = d1;
         2'd2:    y = d2;
         default: y = d3;
      endcase
   end
endmodule

// File: rtl/arb_rr_4_1.sv
// Four-channel round-robin arbiter with burst allowance and a single-entry
// valid/ready output register holding the selected word.
module arb_rr_4_1 import arb_pkg::*; #(
   parameter int MAX_BURST = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_CH-1:0]   in_valid,
   output logic [N_CH-1:0]   in_ready,
   input  logic [DATA_W-1:0] d0,
   input  logic [DATA_W-1:0] d1,
   input  logic [DATA_W-1:0] d2,
   input  logic [DATA_W-1:0] d3,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output ch_t               out_sel
);
   localparam cnt_t MAX_B = cnt_t'(MAX_BURST);

   ch_t               last_q, last_d, gnt;
   cnt_t              cnt_q, cnt_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d, mux_y;
   ch_t               out_sel_q, out_sel_d;
   logic              load, sticky, xfer;

   mux_4_1 u_mux (
      .d0  (d0),
      .d1  (d1),
      .d2  (d2),
      .d3  (d3),
      .sel (gnt),
      .y   (mux_y)
   );

   always_comb begin
      load   = !out_valid_q || out_ready;
      // cnt == 0 only before the first grant, so channel 0 wins out of reset
      sticky = in_valid[last_q] && (cnt_q != '0) && (cnt_q < MAX_B);
      gnt    = sticky ? last_q : rr_pick(in_valid, last_q);
      xfer   = rst_n && load && (|in_valid);
      for (int i = 0; i < N_CH; i++)
         in_ready[i] = xfer && (gnt == ch_t'(i));

      last_d      = last_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = mux_y;
         out_sel_d   = gnt;
         last_d      = gnt;
         if (gnt == last_q) cnt_d = (cnt_q >= MAX_B) ? MAX_B : cnt_q + cnt_t'(1);
         else               cnt_d = cnt_t'(1);
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q      <= ch_t'(3);
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
      end else begin
         last_q      <= last_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;
endmodule

// File: tb/tb_arb_rr_4_1.sv
// Directed bench for arb_rr_4_1: one instance with MAX_BURST=1, one with MAX_BURST=3, shared stimulus.
module tb_arb_rr_4_1;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] in_valid = '0;
   logic [3:0] d0 = 4'ha, d1 = 4'hb, d2 = 4'hc, d3 = 4'hd;
   logic       out_ready = 1'b0;

   logic [3:0] in_ready1, out_data1, in_ready3, out_data3;
   logic       out_valid1, out_valid3;
   logic [1:0] out_sel1, out_sel3;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   arb_rr_4_1 #(.MAX_BURST(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
      .d0(d0), .d1(d1), .d2(d2), .d3(d3),
      .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_sel(out_sel1));

   arb_rr_4_1 #(.MAX_BURST(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3),
      .d0(d0), .d1(d1), .d2(d2), .d3(d3),
      .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3), .out_sel(out_sel3));

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; in_valid = '0; out_ready = 1'b0;
      d0 = 4'ha; d1 = 4'hb; d2 = 4'hc; d3 = 4'hd;
      step();
      @(negedge clk) rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 4'hf; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (in_ready1 !== 4'b0000) begin n_fail++; $display("FAIL reset_in_ready1: got %b expected 0000", in_ready1); end
      n_checks++; if (in_ready3 !== 4'b0000) begin n_fail++; $display("FAIL reset_in_ready3: got %b expected 0000", in_ready3); end
      n_checks++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid1: got %b expected 0", out_valid1); end
      n_checks++; if (out_data1 !== 4'h0) begin n_fail++; $display("FAIL reset_out_data1: got %h expected 0", out_data1); end
      n_checks++; if (out_sel1 !== 2'd0) begin n_fail++; $display("FAIL reset_out_sel1: got %0d expected 0", out_sel1); end
      n_checks++; if (out_valid3 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid3: got %b expected 0", out_valid3); end
      in_valid = '0;
      @(negedge clk) rst_n = 1'b1;
      step();
   endtask

   task automatic test_single();
      do_reset();
      in_valid = 4'b0100; d2 = 4'h9; out_ready = 1'b1;
      #1;
      n_checks++; if (in_ready1 !== 4'b0100) begin n_fail++; $display("FAIL single_in_ready: got %b expected 0100", in_ready1); end
      step();
      in_valid = '0;
      n_checks++; if (out_valid1 !== 1'b1) begin n_fail++; $display("FAIL single_out_valid: got %b expected 1", out_valid1); end
      n_checks++; if (out_data1 !== 4'h9) begin n_fail++; $display("FAIL single_out_data: got %h expected 9", out_data1); end
      n_checks++; if (out_sel1 !== 2'd2) begin n_fail++; $display("FAIL single_out_sel: got %0d expected 2", out_sel1); end
      step();
      n_checks++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL drain_out_valid: got %b expected 0", out_valid1); end
      n_checks++; if (out_data1 !== 4'h9) begin n_fail++; $display("FAIL drain_out_data_hold: got %h expected 9", out_data1); end
   endtask

   task automatic test_round_robin();
      logic [1:0] es;
      logic [3:0] ed;
      do_reset();
      in_valid = 4'hf; out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         es = 2'(i % 4);
         ed = 4'ha + 4'(es);
         n_checks++; if (out_sel1 !== es) begin n_fail++; $display("FAIL rr_sel[%0d]: got %0d expected %0d", i, out_sel1, es); end
         n_checks++; if (out_data1 !== ed) begin n_fail++; $display("FAIL rr_data[%0d]: got %h expected %h", i, out_data1, ed); end
      end
      in_valid = '0;
   endtask

   task automatic test_burst();
      int seq_a [10];
      int seq_b [4];
      seq_a = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3};
      seq_b = '{0, 0, 0, 1};
      do_reset();
      in_valid = 4'hf; out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         n_checks++; if (out_sel3 !== 2'(seq_a[i])) begin n_fail++; $display("FAIL burst_sel[%0d]: got %0d expected %0d", i, out_sel3, seq_a[i]); end
      end
      in_valid = 4'b0111;
      #1;
      n_checks++; if (in_ready3 !== 4'b0001) begin n_fail++; $display("FAIL burst_drop_in_ready: got %b expected 0001", in_ready3); end
      for (int i = 0; i < 4; i++) begin
         step();
         n_checks++; if (out_sel3 !== 2'(seq_b[i])) begin n_fail++; $display("FAIL burst_after_drop[%0d]: got %0d expected %0d", i, out_sel3, seq_b[i]); end
      end
      in_valid = '0;
   endtask

   task automatic test_backpressure();
      do_reset();
      in_valid = 4'b0010; out_ready = 1'b1;
      step();
      in_valid = 4'hf; out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_checks++; if (in_ready1 !== 4'b0000) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b expected 0000", i, in_ready1); end
         step();
         n_checks++; if (out_sel1 !== 2'd1 || out_data1 !== 4'hb || out_valid1 !== 1'b1)
            begin n_fail++; $display("FAIL bp_hold[%0d]: got sel %0d data %h vld %b expected sel 1 data b vld 1", i, out_sel1, out_data1, out_valid1); end
      end
      out_ready = 1'b1;
      #1;
      n_checks++; if (in_ready1 !== 4'b0100) begin n_fail++; $display("FAIL bp_refill_in_ready: got %b expected 0100", in_ready1); end
      step();
      n_checks++; if (out_sel1 !== 2'd2 || out_data1 !== 4'hc || out_valid1 !== 1'b1)
         begin n_fail++; $display("FAIL bp_refill: got sel %0d data %h vld %b expected sel 2 data c vld 1", out_sel1, out_data1, out_valid1); end
      in_valid = '0;
   endtask

   task automatic test_gaps_wrap();
      int seq [3];
      seq = '{0, 3, 0};
      do_reset();
      in_valid = 4'b1001; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++; if (out_sel1 !== 2'(seq[i])) begin n_fail++; $display("FAIL wrap_sel[%0d]: got %0d expected %0d", i, out_sel1, seq[i]); end
      end
      in_valid = '0;
   endtask

   task automatic test_async_reset();
      do_reset();
      in_valid = 4'b1000; out_ready = 1'b1;
      step();
      in_valid = 4'b0110; out_ready = 1'b0;
      n_checks++; if (out_valid1 !== 1'b1) begin n_fail++; $display("FAIL arst_pre_valid: got %b expected 1", out_valid1); end
      #3 rst_n = 1'b0;
      #1;
      n_checks++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL arst_out_valid: got %b expected 0", out_valid1); end
      n_checks++; if (in_ready1 !== 4'b0000) begin n_fail++; $display("FAIL arst_in_ready: got %b expected 0000", in_ready1); end
      #2 rst_n = 1'b1; out_ready = 1'b1;
      #1;
      n_checks++; if (in_ready1 !== 4'b0010) begin n_fail++; $display("FAIL arst_release_in_ready: got %b expected 0010", in_ready1); end
      step();
      n_checks++; if (out_sel1 !== 2'd1 || out_valid1 !== 1'b1) begin n_fail++; $display("FAIL arst_next_grant: got sel %0d vld %b expected sel 1 vld 1", out_sel1, out_valid1); end
      in_valid = '0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_burst();
      test_backpressure();
      test_gaps_wrap();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
